compass_kernel_scheduler: RTL and testbench

- Sequences the eight Robinson compass kernels over one shared 3x3 kernel-MAC datapath for each incoming 3x3 pixel window.
- Generates the signed 3x3 coefficient set for each direction internally and issues window+kernel to the external MAC one direction per cycle.
- Collects the MAC sums, tracks the maximum absolute response and its direction index, and emits a clamped 8-bit edge magnitude plus a 3-bit direction.
- Sits between the window/line-buffer stage and the output image writer.

---
 rtl/compass_kernel_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_compass_kernel_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compass_kernel_scheduler.sv
// Robinson compass edge scheduler: issues the eight 3x3 compass kernels for one window
// to a shared external MAC, then reports the strongest clamped response and its direction.
module compass_kernel_scheduler #(
  parameter int RESULT_TIMEOUT = 64,
  parameter int MAG_MAX        = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        win_valid,
  output logic        win_ready,
  input  logic [71:0] win_data,
  output logic        mac_issue,
  output logic [71:0] mac_window,
  output logic [71:0] mac_kernel,
  input  logic        mac_result_valid,
  input  logic [15:0] mac_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_mag,
  output logic [2:0]  out_dir,
  output logic        out_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, OUTPUT} state_e;

  localparam int          TW        = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [15:0] MAG_MAX_W = 16'(MAG_MAX);

  state_e      state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  res_cnt_q, res_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] max_q, max_d;
  logic [2:0]  arg_q, arg_d;
  logic [71:0] win_q, win_d;
  logic [71:0] kern_q, kern_d;
  logic        issue_q, issue_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  mag_q, mag_d;
  logic [2:0]  dir_q, dir_d;
  logic        err_q, err_d;
  logic [15:0] abs_res;
  logic        res_take;

  // Base ring R0, indexed by ring position offset.
  function automatic logic signed [7:0] ring_coef(input logic [2:0] i);
    logic signed [7:0] c;
    case (i)
      3'd0: c = -8'sd1;
      3'd1: c = -8'sd2;
      3'd2: c = -8'sd1;
      3'd3: c =  8'sd0;
      3'd4: c =  8'sd1;
      3'd5: c =  8'sd2;
      3'd6: c =  8'sd1;
      default: c = 8'sd0;
    endcase
    return c;
  endfunction

  // Clockwise outer ring starting top-left, mapped to raster pixel index.
  function automatic logic [3:0] ring_pos(input logic [2:0] k);
    logic [3:0] p;
    case (k)
      3'd0: p = 4'd0;
      3'd1: p = 4'd1;
      3'd2: p = 4'd2;
      3'd3: p = 4'd5;
      3'd4: p = 4'd8;
      3'd5: p = 4'd7;
      3'd6: p = 4'd6;
      default: p = 4'd3;
    endcase
    return p;
  endfunction

  function automatic logic [71:0] kernel_for(input logic [2:0] d);
    logic [71:0] k;
    logic [2:0]  ki;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      ki = 3'(i);
      k[int'(ring_pos(ki)) * 8 +: 8] = ring_coef(ki + d);
    end
    return k;
  endfunction

  function automatic logic [15:0] abs16(input logic [15:0] v);
    logic [15:0] a;
    if (v == 16'h8000)  a = 16'h7fff;
    else if (v[15])     a = (~v) + 16'd1;
    else                a = v;
    return a;
  endfunction

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    tmo_d       = tmo_q;
    max_d       = max_q;
    arg_d       = arg_q;
    win_d       = win_q;
    kern_d      = kern_q;
    issue_d     = issue_q;
    out_valid_d = out_valid_q;
    mag_d       = mag_q;
    dir_d       = dir_q;
    err_d       = err_q;
    abs_res     = abs16(mac_result);
    res_take    = (state_q == ISSUE || state_q == COLLECT) && mac_result_valid &&
                  (res_cnt_q < 4'd8);

    // Strict compare keeps the lowest direction on ties.
    if (res_take) begin
      res_cnt_d = res_cnt_q + 4'd1;
      if (abs_res > max_q) begin
        max_d = abs_res;
        arg_d = res_cnt_q[2:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          win_d       = win_data;
          kern_d      = kernel_for(3'd0);
          issue_cnt_d = 3'd0;
          issue_d     = 1'b1;
          max_d       = '0;
          arg_d       = '0;
          res_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt_q == 3'd7) begin
          issue_d = 1'b0;
          tmo_d   = TW'(RESULT_TIMEOUT - 1);
          state_d = COLLECT;
        end else begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          kern_d      = kernel_for(issue_cnt_q + 3'd1);
        end
      end
      COLLECT: begin
        if (res_cnt_d == 4'd8 || tmo_q == '0) begin
          state_d     = OUTPUT;
          out_valid_d = 1'b1;
          mag_d       = (max_d > MAG_MAX_W) ? 8'(MAG_MAX) : max_d[7:0];
          dir_d       = arg_d;
          err_d       = (res_cnt_d != 4'd8);
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      tmo_q       <= '0;
      max_q       <= '0;
      arg_q       <= '0;
      win_q       <= '0;
      kern_q      <= '0;
      issue_q     <= 1'b0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      dir_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      tmo_q       <= tmo_d;
      max_q       <= max_d;
      arg_q       <= arg_d;
      win_q       <= win_d;
      kern_q      <= kern_d;
      issue_q     <= issue_d;
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
    end
  end

  assign win_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mac_issue  = issue_q;
  assign mac_window = win_q;
  assign mac_kernel = kern_q;
  assign out_valid  = out_valid_q;
  assign out_mag    = mag_q;
  assign out_dir    = dir_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_compass_kernel_scheduler.sv
// Scoreboard bench for compass_kernel_scheduler with a latency-programmable MAC model.
module tb_compass_kernel_scheduler;
  localparam int RESULT_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        win_valid = 1'b0;
  logic        win_ready;
  logic [71:0] win_data = '0;
  logic        mac_issue;
  logic [71:0] mac_window;
  logic [71:0] mac_kernel;
  logic        mac_result_valid = 1'b0;
  logic [15:0] mac_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_mag;
  logic [2:0]  out_dir;
  logic        out_err;
  logic        busy;

  always #5 clk = ~clk;

  compass_kernel_scheduler #(.RESULT_TIMEOUT(RESULT_TIMEOUT), .MAG_MAX(255)) dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .mac_issue(mac_issue), .mac_window(mac_window), .mac_kernel(mac_kernel),
    .mac_result_valid(mac_result_valid), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_dir(out_dir), .out_err(out_err), .busy(busy)
  );

  typedef struct {int mag; int dir; int err; int lat;} exp_t;
  typedef struct {int sum; int due;} pend_t;
  exp_t  sb[$];
  pend_t pipe[$];

  int errors = 0;
  int checks = 0;
  logic [71:0] cur_win = '0;
  int exp_pulses = 8;
  int mac_limit = 8;
  int mac_lat = 3;
  logic inj_req = 1'b0;
  int inj_val = 0;

  // Hand-written compass kernels, raster order p(0,0)..p(2,2).
  int ktab [8][9] = '{
    '{-1,-2,-1,  0, 0, 0,  1, 2, 1},
    '{-2,-1, 0, -1, 0, 1,  0, 1, 2},
    '{-1, 0, 1, -2, 0, 2, -1, 0, 1},
    '{ 0, 1, 2, -1, 0, 1, -2,-1, 0},
    '{ 1, 2, 1,  0, 0, 0, -1,-2,-1},
    '{ 2, 1, 0,  1, 0,-1,  0,-1,-2},
    '{ 1, 0,-1,  2, 0,-2,  1, 0,-1},
    '{ 0,-1,-2,  1, 0,-1,  2, 1, 0}
  };

  function automatic logic [71:0] kvec(input int d);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(ktab[d][i]);
    return v;
  endfunction

  function automatic logic [71:0] mkwin(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic monitor_loop();
    int issue_idx = 0;
    int mcyc = 0;
    int last_issue = 0;
    logic prev_valid = 1'b0;
    logic prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      mcyc++;
      if (prev_rst) begin
        chk("rst_win_ready", 72'(win_ready), 72'd1);
        chk("rst_mac_issue", 72'(mac_issue), 72'd0);
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_out_mag", 72'(out_mag), 72'd0);
        chk("rst_out_dir", 72'(out_dir), 72'd0);
        chk("rst_out_err", 72'(out_err), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_mac_window", mac_window, 72'd0);
        chk("rst_mac_kernel", mac_kernel, 72'd0);
      end
      if (mac_issue === 1'b1) begin
        if (issue_idx < 8) chk($sformatf("kernel_d%0d", issue_idx), mac_kernel, kvec(issue_idx));
        else bound_fail("extra_issue");
        chk("mac_window", mac_window, cur_win);
        issue_idx++;
        last_issue = mcyc;
      end else if (issue_idx != 0) begin
        chk("issue_pulses", 72'(issue_idx), 72'(exp_pulses));
        issue_idx = 0;
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          bound_fail("unexpected_output");
        end else begin
          chk("out_mag", 72'(out_mag), 72'(sb[0].mag));
          chk("out_dir", 72'(out_dir), 72'(sb[0].dir));
          chk("out_err", 72'(out_err), 72'(sb[0].err));
          chk("win_ready_in_output", 72'(win_ready), 72'd0);
          chk("no_issue_in_output", 72'(mac_issue), 72'd0);
          if (!prev_valid && sb[0].lat >= 0)
            chk("timeout_latency", 72'(mcyc - last_issue), 72'(sb[0].lat));
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = (out_valid === 1'b1);
      prev_rst = rst;
    end
  endtask

  task automatic mac_loop();
    int t = 0;
    int cnt = 0;
    int s;
    logic signed [7:0] kc;
    pend_t p;
    forever begin
      @(negedge clk);
      #1;
      if (mac_issue === 1'b1) begin
        if (cnt < mac_limit) begin
          s = 0;
          for (int i = 0; i < 9; i++) begin
            kc = mac_kernel[i*8 +: 8];
            s += int'(mac_window[i*8 +: 8]) * int'(kc);
          end
          p.sum = s;
          p.due = t + mac_lat;
          pipe.push_back(p);
        end
        cnt++;
      end else begin
        cnt = 0;
      end
      mac_result_valid = 1'b0;
      if (inj_req) begin
        mac_result_valid = 1'b1;
        mac_result = 16'(inj_val);
      end else if (pipe.size() != 0 && pipe[0].due <= t) begin
        mac_result_valid = 1'b1;
        mac_result = 16'(pipe[0].sum);
        void'(pipe.pop_front());
      end
      t++;
    end
  endtask

  task automatic send_window(input logic [71:0] w, input int mag, input int dir,
                             input int err, input int lat, input bit push);
    int n = 0;
    exp_t e;
    win_data = w;
    win_valid = 1'b1;
    while (!win_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("win_ready_wait");
    if (push) begin
      e.mag = mag; e.dir = dir; e.err = err; e.lat = lat;
      sb.push_back(e);
    end
    cur_win = w;
    @(negedge clk);
    win_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) bound_fail("idle_wait");
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("out_valid_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor_loop();
      mac_loop();
    join_none
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-10 window: every kernel sums to zero.
    send_window(mkwin(10,10,10,10,10,10,10,10,10), 0, 0, 0, -1, 1'b1);
    wait_idle();
    // Bottom row 10: d0=+40 ties d4=-40.
    send_window(mkwin(0,0,0,0,0,0,10,10,10), 40, 0, 0, -1, 1'b1);
    wait_idle();
    // Bottom row 100: 400 clamps to 255.
    send_window(mkwin(0,0,0,0,0,0,100,100,100), 255, 0, 0, -1, 1'b1);
    wait_idle();
    // Right column 20: d2=+80 ties d6=-80.
    mac_lat = 1;
    send_window(mkwin(0,0,20,0,0,20,0,0,20), 80, 2, 0, -1, 1'b1);
    wait_idle();
    mac_lat = 0;
    send_window(mkwin(0,0,0,0,0,0,0,0,0), 0, 0, 0, -1, 1'b1);
    wait_idle();
    mac_lat = 3;

    // Output stall with a second window pending.
    out_ready = 1'b0;
    send_window(mkwin(50,0,0,0,0,0,0,0,0), 100, 1, 0, -1, 1'b1);
    wait_out_valid();
    win_data = mkwin(7,0,0,7,0,0,7,0,0);
    win_valid = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    send_window(mkwin(7,0,0,7,0,0,7,0,0), 28, 2, 0, -1, 1'b1);
    wait_idle();

    // Only five results: timeout, then a late result during OUTPUT.
    mac_limit = 5;
    out_ready = 1'b0;
    send_window(mkwin(0,0,0,0,0,0,30,10,0), 70, 3, 1, RESULT_TIMEOUT + 1, 1'b1);
    wait_out_valid();
    inj_val = 1000;
    inj_req = 1'b1;
    @(negedge clk);
    inj_req = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
    mac_limit = 8;

    // Reset on the fourth issue cycle; in-flight results land in IDLE.
    exp_pulses = 4;
    send_window(mkwin(0,0,0,0,0,0,100,100,100), 0, 0, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    exp_pulses = 8;
    send_window(mkwin(0,0,20,0,0,20,0,0,20), 80, 2, 0, -1, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
